// File: rtl/rca_result_stage.sv
// Registered result stage behind the 64-bit ripple-carry adder: derives Z/N/C/V,
// two-entry skid buffer with valid/ready. Optional RCA_RESULT_STICKY_EN adds sticky overflow.
module rca_result_stage #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] S,
    input  logic             Cout,
    input  logic             A_msb,
    input  logic             B_msb,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic [TAG_W-1:0] out_tag,
    input  logic             sticky_clr,
    output logic             sticky_V
);

    // Entry layout: {sum, tag, Z, N, C, V}
    localparam int EW = WIDTH + TAG_W + 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [EW-1:0]   r_out;
    logic [EW-1:0]   r_skid;
    logic [EW-1:0]   w_new_entry;
    logic            w_acc;
    logic            w_dlv;
    logic            w_ld_out_new;
    logic            w_ld_out_skid;
    logic            w_ld_skid;

    function automatic logic [3:0] calc_flags(
        input logic [WIDTH-1:0] s,
        input logic             cout,
        input logic             a_msb,
        input logic             b_msb
    );
        logic z;
        logic n;
        logic v;
        z = (s == '0);
        n = s[WIDTH-1];
        // Signed overflow: same-sign operands producing a sum of the other sign
        v = (a_msb == b_msb) && (s[WIDTH-1] != a_msb);
        return {z, n, cout, v};
    endfunction

    assign w_new_entry = {S, in_tag, calc_flags(S, Cout, A_msb, B_msb)};

    // Handshake is decoded purely from the state register, never from out_ready
    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_acc     = in_valid && in_ready;
    assign w_dlv     = out_valid && out_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_ld_out_new  = 1'b0;
        w_ld_out_skid = 1'b0;
        w_ld_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt  = ST_ONE;
                    w_ld_out_new = 1'b1;
                end
            end
            ST_ONE: begin
                case ({w_acc, w_dlv})
                    2'b11: w_ld_out_new = 1'b1;
                    2'b01: w_state_nxt  = ST_EMPTY;
                    2'b10: begin
                        w_ld_skid   = 1'b1;
                        w_state_nxt = ST_TWO;
                    end
                    default: ;
                endcase
            end
            ST_TWO: begin
                if (w_dlv) begin
                    w_ld_out_skid = 1'b1;
                    w_state_nxt   = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_out_new) begin
                r_out <= w_new_entry;
            end else if (w_ld_out_skid) begin
                r_out <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_new_entry;
            end
        end
    end

    assign R       = r_out[EW-1 -: WIDTH];
    assign out_tag = r_out[4 +: TAG_W];
    assign Z       = r_out[3];
    assign N       = r_out[2];
    assign C       = r_out[1];
    assign V       = r_out[0];

`ifdef RCA_RESULT_STICKY_EN
    logic r_sticky_v;

    // A set from an overflowing deliver outranks a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_v <= 1'b0;
        end else if (w_dlv && r_out[0]) begin
            r_sticky_v <= 1'b1;
        end else if (sticky_clr) begin
            r_sticky_v <= 1'b0;
        end
    end

    assign sticky_V = r_sticky_v;
`else
    logic w_unused_sticky_clr;

    assign w_unused_sticky_clr = sticky_clr;
    assign sticky_V            = 1'b0;
`endif

endmodule

// File: tb/tb_rca_result_stage.sv
// Bench for rca_result_stage: queue-level reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_rca_result_stage;

    localparam int W  = 64;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  S = '0;
    logic          Cout = 1'b0;
    logic          A_msb = 1'b0;
    logic          B_msb = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  R;
    logic          Z, N, C, V;
    logic [TW-1:0] out_tag;
    logic          sticky_clr = 1'b0;
    logic          sticky_V;

    rca_result_stage #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .Cout(Cout), .A_msb(A_msb), .B_msb(B_msb), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .R(R), .Z(Z), .N(N), .C(C), .V(V), .out_tag(out_tag),
        .sticky_clr(sticky_clr), .sticky_V(sticky_V)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0]  r;
        logic [TW-1:0] tag;
        logic [3:0]    flags; // {Z,N,C,V}
    } exp_t;

    exp_t       q[$];
    logic       m_sticky = 1'b0;
    logic [3:0] dlog[$];
    logic       m_dlv, m_acc, m_dv;

    function automatic exp_t mk(input logic [W-1:0] s, input logic cout,
                                input logic a, input logic b, input logic [TW-1:0] tag);
        exp_t e;
        e.r     = s;
        e.tag   = tag;
        e.flags = {(s == 0), s[W-1], cout, ((a == b) && (s[W-1] != a))};
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_sticky = 1'b0;
        end else begin
            m_dlv = (q.size() > 0) && out_ready;
            m_acc = in_valid && (q.size() < 2);
            m_dv  = m_dlv ? q[0].flags[0] : 1'b0;
            if (out_valid && out_ready) dlog.push_back(out_tag);
            if (m_dlv) void'(q.pop_front());
            if (m_acc) q.push_back(mk(S, Cout, A_msb, B_msb, in_tag));
`ifdef RCA_RESULT_STICKY_EN
            m_sticky = m_dv || (m_sticky && !sticky_clr);
`else
            m_sticky = 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mdl_in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("mdl_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("mdl_sticky", 64'(sticky_V), 64'(m_sticky));
            if (q.size() > 0) begin
                chk("mdl_R", R, q[0].r);
                chk("mdl_tag", 64'(out_tag), 64'(q[0].tag));
                chk("mdl_flags", 64'({Z, N, C, V}), 64'(q[0].flags));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] s, input logic cout, input logic a,
                         input logic b, input logic [TW-1:0] tag);
        in_valid = 1'b1;
        S        = s;
        Cout     = cout;
        A_msb    = a;
        B_msb    = b;
        in_tag   = tag;
    endtask

    // Push one result through with out_ready=1 and check the presented flags
    task automatic single(input string name, input logic [W-1:0] s, input logic cout,
                          input logic a, input logic b, input logic [TW-1:0] tag,
                          input logic [3:0] exp_flags);
        out_ready = 1'b1;
        drive(s, cout, a, b, tag);
        step();
        in_valid = 1'b0;
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_R"}, R, s);
        chk({name, "_flags"}, 64'({Z, N, C, V}), 64'(exp_flags));
        chk({name, "_tag"}, 64'(out_tag), 64'(tag));
        step();
        chk({name, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_R", R, 64'd0);
        chk("rst_flags", 64'({Z, N, C, V}), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_sticky", 64'(sticky_V), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        single("t5", 64'h0000_0000_0000_0005, 1'b0, 1'b0, 1'b0, 4'd3, 4'b0000);
        single("zc", 64'h0, 1'b1, 1'b0, 1'b0, 4'd4, 4'b1010);
        single("nv", 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 4'd5, 4'b0101);
        single("n_only", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 4'd6, 4'b0100);
        single("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 4'd7, 4'b0011);

        // Backpressure: tags 1,2 accepted, 3 held off
        sticky_clr = 1'b1;
        out_ready  = 1'b0;
        dlog.delete();
        drive(64'h11, 1'b0, 1'b0, 1'b0, 4'd1);
        step();
        sticky_clr = 1'b0;
        chk("bp_ready_one", 64'(in_ready), 64'd1);
        drive(64'h22, 1'b0, 1'b0, 1'b0, 4'd2);
        step();
        chk("bp_ready_two", 64'(in_ready), 64'd0);
        chk("bp_head", 64'(out_tag), 64'd1);
        drive(64'h33, 1'b0, 1'b0, 1'b0, 4'd3);
        step();
        step();
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_tag", 64'(out_tag), 64'd1);
        chk("bp_hold_R", R, 64'h11);
        out_ready = 1'b1;
        step();
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        chk("bp_second", 64'(out_tag), 64'd2);
        step();
        in_valid = 1'b0;
        chk("bp_third", 64'(out_tag), 64'd3);
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);
        chk("bp_count", 64'(dlog.size()), 64'd3);
        for (int i = 0; i < 3 && i < dlog.size(); i++)
            chk("bp_order", 64'(dlog[i]), 64'(i + 1));

        // Streaming: 16 back-to-back
        dlog.delete();
        for (int i = 0; i < 16; i++) begin
            drive({$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom), 4'(i));
            step();
            chk("st_nobubble", 64'(out_valid), 64'd1);
            chk("st_tag", 64'(out_tag), 64'(i));
        end
        in_valid = 1'b0;
        step();
        chk("st_count", 64'(dlog.size()), 64'd16);
        for (int i = 0; i < 16 && i < dlog.size(); i++)
            chk("st_order", 64'(dlog[i]), 64'(i));

        // Reset from TWO, asserted between edges
        out_ready = 1'b0;
        drive(64'hAA, 1'b0, 1'b0, 1'b0, 4'd9);
        step();
        drive(64'hBB, 1'b0, 1'b0, 1'b0, 4'd10);
        step();
        in_valid = 1'b0;
        chk("mr_two", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid_drop", 64'(out_valid), 64'd0);
        chk("mr_ready", 64'(in_ready), 64'd1);
        chk("mr_R", R, 64'd0);
        chk("mr_tag", 64'(out_tag), 64'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        dlog.delete();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_no_stale", 64'(out_valid), 64'd0);
        end
        chk("mr_no_deliver", 64'(dlog.size()), 64'd0);

        // Sticky overflow
        drive(64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 4'd1);
        step();
        drive(64'h1, 1'b0, 1'b0, 1'b0, 4'd2);
        step();
        in_valid = 1'b0;
`ifdef RCA_RESULT_STICKY_EN
        chk("sv_set", 64'(sticky_V), 64'd1);
        step();
        chk("sv_persist", 64'(sticky_V), 64'd1);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        chk("sv_clear", 64'(sticky_V), 64'd0);
        drive(64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 4'd3);
        step();
        in_valid   = 1'b0;
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        chk("sv_set_wins", 64'(sticky_V), 64'd1);
`else
        chk("sv_tied", 64'(sticky_V), 64'd0);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        chk("sv_tied2", 64'(sticky_V), 64'd0);
`endif
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
